// File: rtl/instr_align_pkg.sv
// instr_align_pkg: shared types for the instruction alignment buffer.
// INSTR_ALIGN_BYPASS_EN (used by instr_align_buf) enables the fetch bypass.
package instr_align_pkg;

  localparam int PC_MAX_W = 64;
  localparam logic [1:0] RVI_OPC = 2'b11;

  typedef struct packed {
    logic [15:0] data;
    logic        load_fault;
    logic        page_fault_x;
  } hw_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    state_e                state;
    logic [PC_MAX_W-1:0]   pc;
  } regs_t;

  localparam regs_t instr_align_r_reset = '{
    state: ST_EMPTY,
    pc:    '0
  };

  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != RVI_OPC;
  endfunction

  function automatic logic hw_fault(input hw_entry_t e);
    return e.load_fault | e.page_fault_x;
  endfunction

endpackage

// File: rtl/instr_align_hwq.sv
// instr_align_hwq: circular halfword FIFO, up to 2 pushes and 2 pops per cycle.
// Pointers carry one extra MSB so full and empty are distinguishable.
module instr_align_hwq
  import instr_align_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_clr,
  input  logic [1:0]    i_push_cnt,
  input  hw_entry_t     i_wdata0,
  input  hw_entry_t     i_wdata1,
  input  logic [1:0]    i_pop_cnt,
  output hw_entry_t     o_rdata0,
  output hw_entry_t     o_rdata1,
  output logic [CW-1:0] o_count
);

  hw_entry_t     mem_q [DEPTH];
  hw_entry_t     mem_d [DEPTH];
  logic [CW-1:0] wr_q, wr_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [AW-1:0] wa0, wa1, ra0, ra1;

  assign wa0 = wr_q[AW-1:0];
  assign wa1 = wa0 + AW'(1);
  assign ra0 = rd_q[AW-1:0];
  assign ra1 = ra0 + AW'(1);

  assign o_rdata0 = mem_q[ra0];
  assign o_rdata1 = mem_q[ra1];
  assign o_count  = wr_q - rd_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q + CW'(i_push_cnt);
    rd_d  = rd_q + CW'(i_pop_cnt);
    if (i_push_cnt != 2'd0) mem_d[wa0] = i_wdata0;
    if (i_push_cnt == 2'd2) mem_d[wa1] = i_wdata1;
    if (i_clr) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/instr_align_buf.sv
// instr_align_buf: splits fetch words into whole RVC/RVI instructions.
// Define INSTR_ALIGN_BYPASS_EN for a zero-latency path from an empty queue.
module instr_align_buf
  import instr_align_pkg::*;
#(
  parameter int HW_DEPTH = 8,
  parameter int PC_W     = 64
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_flush,
  input  logic            i_f_valid,
  output logic            o_f_ready,
  input  logic [PC_W-1:0] i_f_pc,
  input  logic [31:0]     i_f_data,
  input  logic            i_f_load_fault,
  input  logic            i_f_page_fault_x,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output logic [31:0]     o_instr,
  output logic            o_compressed,
  output logic            o_load_fault,
  output logic            o_page_fault_x
);

  localparam int CW = $clog2(HW_DEPTH) + 1;

  regs_t           r_q, r_d;
  hw_entry_t       q0, q1, w0, w1, h0, h1, wd0;
  logic [CW-1:0]   count, avail;
  logic [PC_W-1:0] pc_cur, inc;
  logic [1:0]      in_cnt, push_cnt, pop_cnt, q_pop_cnt;
  logic            ready, push, pop, byp, clr;
  logic            need1, fault, valid;

  assign ready = i_nrst && (r_q.state != ST_HOLD)
              && (count <= CW'(HW_DEPTH - 2));
  assign push  = i_f_valid && ready && !i_flush;
  assign in_cnt = i_f_pc[1] ? 2'd1 : 2'd2;

  assign w0 = '{
    data:         i_f_pc[1] ? i_f_data[31:16] : i_f_data[15:0],
    load_fault:   i_f_load_fault,
    page_fault_x: i_f_page_fault_x
  };
  assign w1 = '{
    data:         i_f_data[31:16],
    load_fault:   i_f_load_fault,
    page_fault_x: i_f_page_fault_x
  };

`ifdef INSTR_ALIGN_BYPASS_EN
  assign byp = i_f_valid && ready && (count == '0)
            && (hw_fault(w0) || is_rvc(w0.data) || !i_f_pc[1]);
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    h0     = q0;
    h1     = q1;
    avail  = count;
    pc_cur = r_q.pc[PC_W-1:0];
    if (byp) begin
      h0     = w0;
      h1     = w1;
      avail  = CW'(in_cnt);
      pc_cur = i_f_pc;
    end
  end

  // A faulted head is handed over alone so the decoder traps on it.
  assign fault = hw_fault(h0);
  assign need1 = fault || is_rvc(h0.data);
  assign valid = (byp || r_q.state == ST_RUN) && (avail != '0)
              && (need1 || avail >= CW'(2));

  assign pop     = valid && i_ready && !i_flush;
  assign pop_cnt = !pop ? 2'd0 : (need1 ? 2'd1 : 2'd2);
  assign inc     = need1 ? PC_W'(2) : PC_W'(4);

  always_comb begin
    push_cnt  = push ? in_cnt : 2'd0;
    q_pop_cnt = pop_cnt;
    wd0       = w0;
    if (byp && pop) begin
      push_cnt  = in_cnt - pop_cnt;
      q_pop_cnt = 2'd0;
      wd0       = w1;
    end
  end

  always_comb begin
    r_d = r_q;
    clr = 1'b0;
    if (i_flush) begin
      r_d.state = ST_EMPTY;
      clr       = 1'b1;
    end else begin
      if (r_q.state == ST_EMPTY && push) begin
        r_d.state = ST_RUN;
        r_d.pc    = PC_MAX_W'(i_f_pc);
      end
      if (pop) begin
        r_d.pc = PC_MAX_W'(pc_cur + inc);
        if (fault) r_d.state = ST_HOLD;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_q <= instr_align_r_reset;
    else         r_q <= r_d;
  end

  instr_align_hwq #(
    .DEPTH (HW_DEPTH)
  ) u_hwq (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_clr      (clr),
    .i_push_cnt (push_cnt),
    .i_wdata0   (wd0),
    .i_wdata1   (w1),
    .i_pop_cnt  (q_pop_cnt),
    .o_rdata0   (q0),
    .o_rdata1   (q1),
    .o_count    (count)
  );

  assign o_f_ready      = ready;
  assign o_valid        = valid;
  assign o_pc           = pc_cur;
  assign o_instr        = !valid ? 32'h0
                        : need1 ? {16'h0, h0.data}
                        : {h1.data, h0.data};
  assign o_compressed   = valid && !fault && is_rvc(h0.data);
  assign o_load_fault   = valid && (h0.load_fault
                        || (!need1 && h1.load_fault));
  assign o_page_fault_x = valid && (h0.page_fault_x
                        || (!need1 && h1.page_fault_x));

endmodule

// File: tb/tb_instr_align_buf.sv
// tb_instr_align_buf: scoreboard bench for instr_align_buf.
// Expected instructions are queued at stimulus time, checked on handshake.
module tb_instr_align_buf;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        c;
    logic        lf;
    logic        pf;
  } txn_t;

  logic        clk, nrst, i_flush, i_f_valid, o_f_ready;
  logic [63:0] i_f_pc, o_pc;
  logic [31:0] i_f_data, o_instr;
  logic        i_f_load_fault, i_f_page_fault_x;
  logic        o_valid, i_ready, o_compressed;
  logic        o_load_fault, o_page_fault_x;

  int   checks = 0;
  int   fails  = 0;
  txn_t exp_q[$];
  txn_t e;

  instr_align_buf #(.HW_DEPTH(8), .PC_W(64)) dut (
    .i_clk            (clk),
    .i_nrst           (nrst),
    .i_flush          (i_flush),
    .i_f_valid        (i_f_valid),
    .o_f_ready        (o_f_ready),
    .i_f_pc           (i_f_pc),
    .i_f_data         (i_f_data),
    .i_f_load_fault   (i_f_load_fault),
    .i_f_page_fault_x (i_f_page_fault_x),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_pc             (o_pc),
    .o_instr          (o_instr),
    .o_compressed     (o_compressed),
    .o_load_fault     (o_load_fault),
    .o_page_fault_x   (o_page_fault_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake observed mid-cycle completes at the following rising edge.
  always @(negedge clk) begin
    if (nrst && o_valid && i_ready && !i_flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected pc=%h instr=%h", o_pc, o_instr);
      end else begin
        e = exp_q.pop_front();
        if ({o_pc, o_instr, o_compressed, o_load_fault,
             o_page_fault_x} !== e) begin
          fails++;
          $display("FAIL sb_out got pc=%h i=%h c=%b lf=%b pf=%b exp pc=%h i=%h c=%b lf=%b pf=%b",
                   o_pc, o_instr, o_compressed, o_load_fault,
                   o_page_fault_x, e.pc, e.instr, e.c, e.lf, e.pf);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void exp_push(input logic [63:0] pc,
    input logic [31:0] ins, input logic c, input logic lf,
    input logic pf);
    exp_q.push_back('{pc: pc, instr: ins, c: c, lf: lf, pf: pf});
  endfunction

  task automatic push_word(input logic [63:0] pc,
    input logic [31:0] d, input logic lf, input logic pf);
    int n = 0;
    i_f_valid = 1'b1;
    i_f_pc = pc;
    i_f_data = d;
    i_f_load_fault = lf;
    i_f_page_fault_x = pf;
    while (!o_f_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!o_f_ready) begin
      fails++;
      $display("FAIL push_timeout pc=%h o_f_ready=%b exp=1", pc, o_f_ready);
    end
    tick();
    i_f_valid = 1'b0;
    i_f_load_fault = 1'b0;
    i_f_page_fault_x = 1'b0;
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic flush();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #2;
    checks++;
    if ({o_valid, o_f_ready, o_pc, o_instr, o_load_fault,
         o_page_fault_x} !== '0) begin
      fails++;
      $display("FAIL reset_outs v=%b rdy=%b pc=%h i=%h lf=%b pf=%b exp all 0",
               o_valid, o_f_ready, o_pc, o_instr, o_load_fault, o_page_fault_x);
    end
    #10;
    nrst = 1'b1;
    tick();
    checks++;
    if (o_f_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_exit rdy=%b v=%b exp rdy=1 v=0", o_f_ready, o_valid);
    end
  endtask

  task automatic test_rvi();
    i_ready = 1'b0;
    push_word(64'h8000_0000, 32'h00A0_0513, 1'b0, 1'b0);
    checks++;
    if ({o_valid, o_pc, o_instr, o_compressed} !==
        {1'b1, 64'h8000_0000, 32'h00A0_0513, 1'b0}) begin
      fails++;
      $display("FAIL rvi_latency v=%b pc=%h i=%h c=%b exp 1/80000000/00a00513/0",
               o_valid, o_pc, o_instr, o_compressed);
    end
    exp_push(64'h8000_0000, 32'h00A0_0513, 1'b0, 1'b0, 1'b0);
    wait_sb(20);
  endtask

  task automatic test_rvc_pair();
    flush();
    exp_push(64'h100, 32'h0000_4505, 1'b1, 1'b0, 1'b0);
    exp_push(64'h102, 32'h0000_0505, 1'b1, 1'b0, 1'b0);
    i_ready = 1'b1;
    push_word(64'h100, 32'h0505_4505, 1'b0, 1'b0);
    wait_sb(20);
  endtask

  task automatic test_straddle();
    flush();
    exp_push(64'h200, 32'h0000_4505, 1'b1, 1'b0, 1'b0);
    i_ready = 1'b1;
    push_word(64'h200, 32'h0513_4505, 1'b0, 1'b0);
    wait_sb(20);
    repeat (3) tick();
    checks++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL straddle_wait v=%b exp=0", o_valid);
    end
    exp_push(64'h202, 32'h00A0_0513, 1'b0, 1'b0, 1'b0);
    exp_push(64'h206, 32'h0000_4505, 1'b1, 1'b0, 1'b0);
    push_word(64'h204, 32'h4505_00A0, 1'b0, 1'b0);
    wait_sb(20);
  endtask

  task automatic test_flush();
    flush();
    i_ready = 1'b0;
    push_word(64'h300, 32'h4505_4505, 1'b0, 1'b0);
    i_ready = 1'b1;
    i_flush = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_cycle_valid v=%b exp=1", o_valid);
    end
    tick();
    i_flush = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_empty v=%b exp=0", o_valid);
    end
    exp_push(64'h302, 32'h0000_4505, 1'b1, 1'b0, 1'b0);
    push_word(64'h302, 32'h4505_FFFF, 1'b0, 1'b0);
    wait_sb(20);
  endtask

  task automatic test_full();
    flush();
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_push(64'h500 + 64'(4 * k), 32'h00A0_0513, 1'b0, 1'b0, 1'b0);
      push_word(64'h500 + 64'(4 * k), 32'h00A0_0513, 1'b0, 1'b0);
    end
    repeat (2) tick();
    checks++;
    if ({o_f_ready, o_valid, o_pc, o_instr} !==
        {1'b0, 1'b1, 64'h500, 32'h00A0_0513}) begin
      fails++;
      $display("FAIL full_hold rdy=%b v=%b pc=%h i=%h exp 0/1/500/00a00513",
               o_f_ready, o_valid, o_pc, o_instr);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    checks++;
    if (o_f_ready !== 1'b1 || o_pc !== 64'h504) begin
      fails++;
      $display("FAIL full_reopen rdy=%b pc=%h exp 1/504", o_f_ready, o_pc);
    end
    wait_sb(20);
  endtask

  task automatic test_load_fault();
    flush();
    i_ready = 1'b0;
    push_word(64'h400, 32'h00A0_0513, 1'b1, 1'b0);
    checks++;
    if ({o_valid, o_pc, o_load_fault, o_instr, o_compressed} !==
        {1'b1, 64'h400, 1'b1, 32'h0000_0513, 1'b0}) begin
      fails++;
      $display("FAIL lf_out v=%b pc=%h lf=%b i=%h c=%b exp 1/400/1/00000513/0",
               o_valid, o_pc, o_load_fault, o_instr, o_compressed);
    end
    exp_push(64'h400, 32'h0000_0513, 1'b0, 1'b1, 1'b0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (o_valid !== 1'b0 || o_f_ready !== 1'b0) begin
      fails++;
      $display("FAIL lf_hold v=%b rdy=%b exp 0/0", o_valid, o_f_ready);
    end
    flush();
    checks++;
    if (o_f_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL lf_release rdy=%b v=%b exp 1/0", o_f_ready, o_valid);
    end
    wait_sb(5);
  endtask

  task automatic test_page_fault();
    flush();
    exp_push(64'h600, 32'h0000_4505, 1'b1, 1'b0, 1'b0);
    exp_push(64'h602, 32'h00A0_0513, 1'b0, 1'b0, 1'b1);
    exp_push(64'h606, 32'h0000_4505, 1'b0, 1'b0, 1'b1);
    i_ready = 1'b1;
    push_word(64'h600, 32'h0513_4505, 1'b0, 1'b0);
    push_word(64'h604, 32'h4505_00A0, 1'b0, 1'b1);
    wait_sb(20);
    tick();
    checks++;
    if (o_f_ready !== 1'b0 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL pf_hold rdy=%b v=%b exp 0/0", o_f_ready, o_valid);
    end
    flush();
  endtask

  task automatic test_pc_wrap();
    flush();
    exp_push(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_4505, 1'b1, 1'b0, 1'b0);
    exp_push(64'hFFFF_FFFF_FFFF_FFFE, 32'h00A0_0513, 1'b0, 1'b0, 1'b0);
    exp_push(64'h2, 32'h0000_4505, 1'b1, 1'b0, 1'b0);
    i_ready = 1'b1;
    push_word(64'hFFFF_FFFF_FFFF_FFFC, 32'h0513_4505, 1'b0, 1'b0);
    push_word(64'h0, 32'h4505_00A0, 1'b0, 1'b0);
    wait_sb(20);
  endtask

  task automatic test_async_reset();
    flush();
    i_ready = 1'b0;
    push_word(64'h700, 32'h4505_4505, 1'b0, 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_f_ready, o_pc, o_instr} !== '0) begin
      fails++;
      $display("FAIL async_rst v=%b rdy=%b pc=%h i=%h exp all 0",
               o_valid, o_f_ready, o_pc, o_instr);
    end
    @(negedge clk);
    nrst = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_f_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_exit v=%b rdy=%b exp 0/1", o_valid, o_f_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] hws[$];
    logic [63:0] pc;
    logic [31:0] r;
    int nw;
    flush();
    pc = 64'h1000;
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      if (r[16]) begin
        if (r[1:0] == 2'b11) r[1:0] = 2'b01;
        hws.push_back(r[15:0]);
        exp_push(pc, {16'h0, r[15:0]}, 1'b1, 1'b0, 1'b0);
        pc += 64'd2;
      end else begin
        r[1:0] = 2'b11;
        hws.push_back(r[15:0]);
        hws.push_back(r[31:16]);
        exp_push(pc, r, 1'b0, 1'b0, 1'b0);
        pc += 64'd4;
      end
    end
    if (hws.size() % 2 != 0) begin
      hws.push_back(16'h4505);
      exp_push(pc, 32'h0000_4505, 1'b1, 1'b0, 1'b0);
    end
    nw = hws.size() / 2;
    fork
      begin
        for (int k = 0; k < nw; k++)
          push_word(64'h1000 + 64'(4 * k),
                    {hws[2 * k + 1], hws[2 * k]}, 1'b0, 1'b0);
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          i_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_sb(200);
  endtask

  initial begin
    nrst = 1'b0;
    i_flush = 1'b0;
    i_f_valid = 1'b0;
    i_f_pc = '0;
    i_f_data = '0;
    i_f_load_fault = 1'b0;
    i_f_page_fault_x = 1'b0;
    i_ready = 1'b0;
    test_reset();
    test_rvi();
    test_rvc_pair();
    test_straddle();
    test_flush();
    test_full();
    test_load_fault();
    test_page_fault();
    test_pc_wrap();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_align_buf.md
Name: instr_align_buf

Overview:
- Sits between the fetch stage and the instruction decoders (RVC and base-ISA).
- Takes 32-bit fetch words, which may hold mixed 16/32-bit instructions, and turns them into one whole instruction per handshake, tagged with its pc.
- Puts back together 32-bit instructions that straddle a word boundary.
- Carries fetch fault flags through so the decoder can capture them in its instr_load_fault and instr_page_fault_x fields.

Parameters:
- HW_DEPTH, 8, depth of the halfword queue; power of 2, minimum 4.
- PC_W, 64, width of all pc buses; equals RISCV_ARCH.

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_flush  in  1  pipeline flush (trap, mispredict, fence.i)
- i_f_valid  in  1  fetch word valid
- o_f_ready  out  1  buffer can accept a fetch word
- i_f_pc  in  PC_W  pc of the word; bit0 is always 0; bit1=1 means only the upper halfword is used
- i_f_data  in  32  fetch word, 4-byte aligned
- i_f_load_fault  in  1  access fault on this word
- i_f_page_fault_x  in  1  execute page fault on this word
- o_valid  out  1  instruction available
- i_ready  in  1  decoder accepts the instruction
- o_pc  out  PC_W  instruction pc
- o_instr  out  32  instruction; upper 16 bits are zero when compressed
- o_compressed  out  1  o_instr[1:0] != 2'b11
- o_load_fault  out  1  fault flag on any halfword of the instruction
- o_page_fault_x  out  1  fault flag on any halfword of the instruction

Behaviour:
- State FSM: EMPTY, RUN, HOLD.
  - Reset: state EMPTY, queue empty, head pc 0.
  - Reset outputs: o_valid=0, o_f_ready=0 while i_nrst=0 then 1, o_pc=0, o_instr=0, flags=0.
- Queue: circular buffer of HW_DEPTH halfword entries {data[15:0], load_fault, page_fault_x}.
  - wr/rd pointers are log2(HW_DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2*HW_DEPTH.
- Push: when i_f_valid && o_f_ready.
  - Push 2 halfwords, or 1 (upper only) if i_f_pc[1]=1.
  - o_f_ready = (free slots >= 2) && state != HOLD.
- EMPTY to RUN on the first push; head pc is loaded with i_f_pc.
  - In RUN, pushed words are required to be sequential.
  - A pc mismatch is not checked.
- Instruction readiness:
  - Head halfword [1:0] != 2'b11 needs 1 halfword.
  - Otherwise it needs 2; o_valid=1 only when the required count is present.
  - If the head halfword carries a fault, o_valid=1 with 1 halfword, o_compressed=0 and o_instr={16'h0,head}.
- Outputs are derived from registered queue state only. There is no combinational input-to-output path unless the optional feature is enabled.
  - Latency from push to o_valid: 1 cycle.
- Pop: when o_valid && i_ready.
  - Read pointer advances by 1 or 2 halfwords.
  - Head pc advances by 2 or 4, wrapping modulo 2^PC_W.
  - Push and pop in the same cycle are allowed; the count updates by the net amount.
- A faulted instruction popped in RUN moves the FSM to HOLD.
  - In HOLD: o_valid=0, o_f_ready=0, and the queue contents are discarded on exit.
- Flush:
  - i_flush=1 empties the queue and moves to EMPTY in the next cycle.
  - It overrides a simultaneous push or pop; the pushed word is dropped.
  - The o_valid of the flush cycle is still visible, but a pop in that cycle is ignored.
- Upper half of a 32-bit instruction not yet arrived: o_valid=0 and the lower half is retained.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro: INSTR_ALIGN_BYPASS_EN.
- Defined: when the queue is empty and the incoming word supplies a complete instruction at its first used halfword, the outputs are driven combinationally from i_f_*.
  - Latency is 0.
  - If the word is accepted and popped in the same cycle, only the unused remainder is written.
- Undefined: no bypass; latency is always at least 1.

Decomposition:
- Package instr_align_pkg holds:
  - the halfword entry struct;
  - the FSM state enum;
  - the registers struct;
  - the reset const instr_align_r_reset;
  - the localparam for the compressed test.
- Sub-module instr_align_hwq is the generic halfword FIFO with 2-in/2-out counts.
- instr_align_buf contains the FSM, pc tracking and instruction assembly.

Test Plan:
- Reset, then push pc=0x80000000 data=0x00A00513 -> next cycle o_valid=1, o_pc=0x80000000, o_instr=0x00A00513, o_compressed=0.
- Push pc=0x100 data=0x05054505 with i_ready=1 -> pc 0x100 instr 0x00004505 compressed=1, then pc 0x102 instr 0x00000505.
- Push pc=0x200 data=0x05134505, then pc=0x204 data=0x450500A0 -> outputs in order:
  - 0x200/0x4505;
  - 0x202/0x00A00513 (no o_valid before the second word arrives);
  - 0x206/0x4505.
- i_flush, then push pc=0x302 data=0x4505FFFF -> one output, pc 0x302 instr 0x4505; the low halfword is discarded.
- Hold i_ready=0 and push until full (HW_DEPTH=8, 4 words) -> o_f_ready=0, o_pc/o_instr stable; the first pop re-enables o_f_ready.
- Push pc=0x400 with i_f_load_fault=1 -> o_valid, o_pc=0x400, o_load_fault=1; after the pop, state HOLD, o_f_ready=0 until i_flush.
